// File: rtl/mdio_arbiter.sv
// Two-port round-robin arbiter in front of the shared MDIO engine.
// Each grant runs one engine transaction through the level handshake, guarded by a timeout.
module mdio_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TW             = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [4:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [4:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [15:0] b_rdata,
  output logic        m_rd_request,
  output logic        m_wr_request,
  output logic [4:0]  m_addr,
  output logic [15:0] m_wr_data,
  input  logic        m_ready,
  input  logic [15:0] m_rd_data,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          wr_flag, wr_flag_n;
  logic          owner_n, busy_n;
  logic          m_rd_request_n, m_wr_request_n;
  logic [4:0]    m_addr_n;
  logic [15:0]   m_wr_data_n;
  logic          a_ack_n, a_err_n, b_ack_n, b_err_n;
  logic [15:0]   a_rdata_n, b_rdata_n;
  logic          grant_b;
  logic          fin, fin_to;
  logic [15:0]   fin_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      wr_flag      <= 1'b0;
      owner        <= 1'b1;
      busy         <= 1'b0;
      m_rd_request <= 1'b0;
      m_wr_request <= 1'b0;
      m_addr       <= '0;
      m_wr_data    <= '0;
      a_ack        <= 1'b0;
      a_err        <= 1'b0;
      a_rdata      <= '0;
      b_ack        <= 1'b0;
      b_err        <= 1'b0;
      b_rdata      <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      wr_flag      <= wr_flag_n;
      owner        <= owner_n;
      busy         <= busy_n;
      m_rd_request <= m_rd_request_n;
      m_wr_request <= m_wr_request_n;
      m_addr       <= m_addr_n;
      m_wr_data    <= m_wr_data_n;
      a_ack        <= a_ack_n;
      a_err        <= a_err_n;
      a_rdata      <= a_rdata_n;
      b_ack        <= b_ack_n;
      b_err        <= b_err_n;
      b_rdata      <= b_rdata_n;
    end
  end

  // On a tie the port that did not win last time gets the engine.
  assign grant_b = (a_req && b_req) ? ~owner : b_req;

  always_comb begin
    state_n        = state;
    timer_n        = timer;
    wr_flag_n      = wr_flag;
    owner_n        = owner;
    m_rd_request_n = m_rd_request;
    m_wr_request_n = m_wr_request;
    m_addr_n       = m_addr;
    m_wr_data_n    = m_wr_data;
    a_ack_n        = 1'b0;
    a_err_n        = 1'b0;
    b_ack_n        = 1'b0;
    b_err_n        = 1'b0;
    a_rdata_n      = a_rdata;
    b_rdata_n      = b_rdata;
    fin            = 1'b0;
    fin_to         = 1'b0;
    fin_data       = m_rd_data;

    case (state)
      IDLE: begin
        if (m_ready && (a_req || b_req)) begin
          owner_n        = grant_b;
          wr_flag_n      = grant_b ? b_wr : a_wr;
          m_addr_n       = grant_b ? b_addr : a_addr;
          m_wr_data_n    = grant_b ? b_wdata : a_wdata;
          m_wr_request_n = grant_b ? b_wr : a_wr;
          m_rd_request_n = grant_b ? ~b_wr : ~a_wr;
          timer_n        = '0;
          state_n        = REQ;
        end
      end
      REQ: begin
        if (!m_ready) begin
          m_rd_request_n = 1'b0;
          m_wr_request_n = 1'b0;
          timer_n        = '0;
          state_n        = RUN;
        end else if (timer == TMAX) begin
          m_rd_request_n = 1'b0;
          m_wr_request_n = 1'b0;
          fin            = 1'b1;
          fin_to         = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      RUN: begin
        if (m_ready) begin
          fin = 1'b1;
        end else if (timer == TMAX) begin
          fin    = 1'b1;
          fin_to = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Completion: ack is registered so it is visible for exactly the DONE cycle.
    if (fin) begin
      state_n = DONE;
      if (fin_to) fin_data = 16'hFFFF;
      if (!owner) begin
        a_ack_n = 1'b1;
        a_err_n = fin_to;
        if (!wr_flag) a_rdata_n = fin_data;
      end else begin
        b_ack_n = 1'b1;
        b_err_n = fin_to;
        if (!wr_flag) b_rdata_n = fin_data;
      end
    end
  end

  assign busy_n = (state_n != IDLE);

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter with a behavioural MDIO engine model.
`timescale 1ns/1ps
module tb_mdio_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_wr = 1'b0;
  logic [4:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        a_ack, a_err;
  logic [15:0] a_rdata;
  logic        b_req = 1'b0, b_wr = 1'b0;
  logic [4:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_ack, b_err;
  logic [15:0] b_rdata;
  logic        m_rd_request, m_wr_request;
  logic [4:0]  m_addr;
  logic [15:0] m_wr_data;
  logic        m_ready = 1'b1;
  logic [15:0] m_rd_data = '0;
  logic        busy, owner;

  int checks = 0;
  int errors = 0;
  int b_ack_cnt = 0;
  int n;
  bit saw_busy;

  // Engine model: 0 = normal, 1 = never accepts, 2 = accepts but never finishes.
  int          eng_mode = 0;
  int          eng_delay = 5;
  logic [15:0] eng_data = '0;
  logic        eng_busy = 1'b0;
  int          eng_cnt = 0;

  mdio_arbiter dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .m_rd_request(m_rd_request), .m_wr_request(m_wr_request),
    .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_ready(m_ready), .m_rd_data(m_rd_data),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (eng_busy) begin
      if (eng_cnt == 0 && eng_mode != 2) begin
        m_ready   <= 1'b1;
        m_rd_data <= eng_data;
        eng_busy  <= 1'b0;
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
      end
    end else if (m_ready && (m_rd_request || m_wr_request) && eng_mode != 1) begin
      m_ready  <= 1'b0;
      eng_busy <= 1'b1;
      eng_cnt  <= eng_delay;
    end
  end

  always @(negedge clock) if (b_ack) b_ack_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit port_b, input logic req, input logic wr,
                               input logic [4:0] addr, input logic [15:0] wdata);
    if (port_b) begin
      b_req = req; b_wr = wr; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_wr = wr; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic waitAck(input bit port_b, input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (((port_b ? b_ack : a_ack) == 1'b0) && cnt < limit);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 1);
    checkOutput("rst_acks", {a_ack, b_ack, a_err, b_err}, 0);
    checkOutput("rst_mreq", {m_rd_request, m_wr_request}, 0);
    checkOutput("rst_maddr", m_addr, 0);
    reset = 1'b0;
    @(negedge clock);

    // Port A read of register 31, engine busy for 130 cycles
    $display("[TB] port A read");
    eng_delay = 130; eng_data = 16'h0068;
    applyStimulus(0, 1, 0, 5'd31, 16'h0);
    @(negedge clock);
    checkOutput("a_rd_req", {m_rd_request, m_wr_request}, 2'b10);
    checkOutput("a_rd_addr", m_addr, 31);
    checkOutput("a_rd_owner", owner, 0);
    checkOutput("a_rd_busy", busy, 1);
    n = 0;
    while (m_ready && n < 20) begin @(negedge clock); n++; end
    checkOutput("a_rd_req_held", m_rd_request, 1);
    @(negedge clock);
    checkOutput("a_rd_req_drop", m_rd_request, 0);
    n = 0;
    while (!m_ready && n < 300) begin @(negedge clock); n++; end
    checkOutput("a_rd_ready_back", m_ready, 1);
    checkOutput("a_rd_ack_early", a_ack, 0);
    @(negedge clock);
    checkOutput("a_rd_ack", a_ack, 1);
    checkOutput("a_rd_err", a_err, 0);
    checkOutput("a_rd_data", a_rdata, 16'h0068);
    applyStimulus(0, 0, 0, 5'd0, 16'h0);
    repeat (2) @(negedge clock);
    checkOutput("a_rd_no_back", b_ack_cnt, 0);
    checkOutput("a_rd_idle", busy, 0);

    // Port B write of register 11
    $display("[TB] port B write");
    eng_delay = 5;
    applyStimulus(1, 1, 1, 5'd11, 16'h8104);
    @(negedge clock);
    checkOutput("b_wr_req", {m_rd_request, m_wr_request}, 2'b01);
    checkOutput("b_wr_data", m_wr_data, 16'h8104);
    checkOutput("b_wr_addr", m_addr, 11);
    waitAck(1, 50, n);
    checkOutput("b_wr_ack", b_ack, 1);
    checkOutput("b_wr_err", b_err, 0);
    checkOutput("b_wr_rdata", b_rdata, 0);
    checkOutput("b_wr_no_aack", a_ack, 0);
    applyStimulus(1, 0, 0, 5'd0, 16'h0);
    repeat (2) @(negedge clock);

    // Contention out of reset: A, B, A, B
    $display("[TB] round robin");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    eng_data = 16'h1234;
    applyStimulus(0, 1, 0, 5'd1, 16'h0);
    applyStimulus(1, 1, 0, 5'd2, 16'h0);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!(a_ack || b_ack) && n < 50);
      checkOutput("rr_ack_seen", a_ack | b_ack, 1);
      checkOutput("rr_order", b_ack, i % 2);
      checkOutput("rr_owner", owner, i % 2);
      if (i % 2 == 0) checkOutput("rr_a_data", a_rdata, 16'h1234);
    end
    applyStimulus(0, 0, 0, 5'd0, 16'h0);
    applyStimulus(1, 0, 0, 5'd0, 16'h0);
    repeat (2) @(negedge clock);

    // Engine never accepts: timeout in REQ
    $display("[TB] timeout in REQ");
    eng_mode = 1;
    applyStimulus(0, 1, 0, 5'd7, 16'h0);
    waitAck(0, 1100, n);
    checkOutput("to_req_ack", a_ack, 1);
    checkOutput("to_req_err", a_err, 1);
    checkOutput("to_req_rdata", a_rdata, 16'hFFFF);
    checkOutput("to_req_cycles", (n >= 1020 && n <= 1030), 1);
    applyStimulus(0, 0, 0, 5'd0, 16'h0);
    eng_mode = 0;
    repeat (2) @(negedge clock);
    checkOutput("to_req_idle", {busy, m_rd_request}, 0);

    // Engine accepts but never returns: timeout in RUN
    $display("[TB] timeout in RUN");
    eng_mode = 2;
    applyStimulus(1, 1, 0, 5'd9, 16'h0);
    waitAck(1, 1200, n);
    checkOutput("to_run_ack", b_ack, 1);
    checkOutput("to_run_err", b_err, 1);
    checkOutput("to_run_rdata", b_rdata, 16'hFFFF);
    checkOutput("to_run_cycles", (n >= 1020 && n <= 1035), 1);
    applyStimulus(1, 0, 0, 5'd0, 16'h0);
    eng_mode = 0;
    repeat (4) @(negedge clock);

    // Reset while the engine is mid-frame
    $display("[TB] reset during RUN");
    eng_delay = 60; eng_data = 16'h00AB;
    applyStimulus(0, 1, 0, 5'd3, 16'h0);
    repeat (10) @(negedge clock);
    checkOutput("mid_busy", {busy, m_ready}, 2'b10);
    reset = 1'b1;
    applyStimulus(1, 1, 0, 5'd4, 16'h0);
    @(negedge clock);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_owner", owner, 1);
    checkOutput("mid_rst_rdata", {a_rdata, b_rdata}, 0);
    checkOutput("mid_rst_m", {m_rd_request, m_wr_request, m_addr}, 0);
    reset = 1'b0;
    eng_delay = 5;
    saw_busy = 1'b0;
    n = 0;
    while (!m_ready && n < 200) begin
      @(negedge clock);
      n++;
      if (busy && !m_ready) saw_busy = 1'b1;
    end
    checkOutput("mid_wait_ready", saw_busy, 0);
    waitAck(0, 100, n);
    checkOutput("mid_a_ack", a_ack, 1);
    checkOutput("mid_a_owner", owner, 0);
    checkOutput("mid_a_data", a_rdata, 16'h00AB);
    checkOutput("mid_no_back", b_ack, 0);
    applyStimulus(0, 0, 0, 5'd0, 16'h0);
    waitAck(1, 100, n);
    checkOutput("mid_b_ack", b_ack, 1);
    checkOutput("mid_b_owner", owner, 1);
    applyStimulus(1, 0, 0, 5'd0, 16'h0);
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_arbiter.md
Name: mdio_arbiter

Overview:
- Shares the single MDIO engine (the `mdio` module: addr, rd_request, wr_request, ready, rd_data, wr_data) between two requesters.
- Port A is the PHY init/status sequencer. Port B is host-commanded PHY register access, taken from the PC-side command path.
- Grants alternate round-robin on contention.
- Each transaction is sequenced through the engine's level handshake, and a hung engine is caught by a timeout.
- The block sits between the requesters and `mdio_inst` in the Ethernet clock domain (2.5 MHz).

Parameters:
- TIMEOUT_CYCLES, 1023: maximum number of clock cycles spent in REQ or in RUN before the transaction is aborted with an error.
- TW, 10: timer width. Must satisfy 2**TW > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- a_req  in  1  port A request. Held high, with a_wr/a_addr/a_wdata stable, until a_ack.
- a_wr  in  1  1 = write, 0 = read.
- a_addr  in  5  MDIO register address.
- a_wdata  in  16  write data.
- a_ack  out  1  one-cycle completion pulse.
- a_err  out  1  valid with a_ack; 1 = timeout.
- a_rdata  out  16  read result; valid from a_ack until the next port A read completes.
- b_req, b_wr, b_addr, b_wdata, b_ack, b_err, b_rdata: identical to port A, for port B.
- m_rd_request  out  1  to engine rd_request.
- m_wr_request  out  1  to engine wr_request.
- m_addr  out  5  to engine addr.
- m_wr_data  out  16  to engine wr_data.
- m_ready  in  1  engine idle / transaction complete.
- m_rd_data  in  16  engine read data, valid when m_ready rises.
- busy  out  1  high in every state except IDLE.
- owner  out  1  current or last grant; 0 = A, 1 = B.

Behaviour:
- Reset values:
  - state = IDLE; all acks, errs, m_rd_request, m_wr_request = 0.
  - m_addr = 0; m_wr_data = 0; a_rdata = b_rdata = 0.
  - owner = 1, so A wins the first tie. Timer = 0.
- All outputs are registered.
- States: IDLE, REQ, RUN, DONE.
- IDLE:
  - No grant while m_ready = 0. This covers an engine still mid-frame after a reset.
  - If m_ready = 1 and exactly one req is high, grant that port.
  - If both are high, grant the port != owner.
  - On grant: latch wr/addr/wdata into m_addr/m_wr_data and an internal wr flag; set owner; clear timer; go to REQ.
- REQ:
  - Drive m_wr_request = wr, m_rd_request = !wr.
  - On m_ready = 0: drop both requests next cycle, clear timer, go to RUN.
  - If timer reaches TIMEOUT_CYCLES: drop requests, set the error flag, go to DONE.
- RUN:
  - Requests stay low; timer increments.
  - On m_ready = 1: for a read, capture m_rd_data into the owner's rdata; go to DONE.
  - If timer reaches TIMEOUT_CYCLES: set the error flag, go to DONE.
- DONE:
  - Pulse the owner's ack for exactly one cycle, with err = error flag.
  - Timed-out read: owner's rdata = 16'hFFFF.
  - Write: rdata unchanged.
  - Clear the error flag; go to IDLE.
- Requesters must drop req the cycle after ack. A req still high in IDLE is a new transaction.
- Latency, no contention, engine responds immediately:
  - Grant 1 cycle after req.
  - Request asserted from the REQ cycle until m_ready is seen low.
  - ack 1 cycle after m_ready is seen high in RUN.
- Changes on a port's inputs after grant are ignored. The latched copy is used.
- The non-owner's ack/err are never asserted.
- The timer saturates at TIMEOUT_CYCLES and never wraps.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; no ack is issued.
  - The requester re-requests.
  - The engine's frame finishes on its own; IDLE waits for m_ready.

Test Plan:
- Port A read of addr 31 only, engine model returning 16'h0068 after 130 cycles busy -> m_rd_request high until m_ready low, m_addr = 31; a_ack 1 cycle after m_ready rises; a_rdata = 16'h0068, a_err = 0; b_ack never pulses.
- Port B write of addr 11 data 16'h8104 -> m_wr_request (not m_rd_request) asserted, m_wr_data = 16'h8104; b_ack pulse, b_rdata unchanged at 0.
- a_req and b_req asserted together, both held after each ack for 4 transactions -> grant order A, B, A, B out of reset; owner toggles each grant.
- Engine model never drops m_ready after the request -> abort after 1023 cycles in REQ; ack with err = 1; for a read, rdata = 16'hFFFF; return to IDLE.
- Engine goes busy but never returns ready -> err ack after 1023 RUN cycles.
- reset pulsed during RUN with the engine still busy -> all outputs at reset values next cycle; a pending req is not granted until m_ready = 1; then it completes normally with owner = A on a tie.
